// File: rtl/render_cmd_pkg.sv
// Shared definitions for the render command queue: opcodes, field positions,
// the sprite slot entry layout and the reader FSM states.
package render_cmd_pkg;

    localparam int CMD_W = 48;

    localparam logic [3:0] OP_NOP        = 4'd0;
    localparam logic [3:0] OP_SET        = 4'd1;
    localparam logic [3:0] OP_CLEAR_SLOT = 4'd2;
    localparam logic [3:0] OP_CLEAR_ALL  = 4'd3;
    localparam logic [3:0] OP_COMMIT     = 4'd4;

    localparam int OP_LSB       = 44;
    localparam int OP_W         = 4;
    localparam int SLOT_LSB     = 38;
    localparam int SLOT_FIELD_W = 6;
    localparam int X_LSB        = 28;
    localparam int Y_LSB        = 18;
    localparam int COORD_W      = 10;
    localparam int BASE_LSB     = 9;
    localparam int BASE_W       = 9;

    typedef struct packed {
        logic        valid;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [8:0]  base;
    } slot_entry_t;

    localparam int ENTRY_W = $bits(slot_entry_t);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_CLEAR,
        ST_WAIT_FRAME,
        ST_COPY
    } state_t;

    // Builds a command word with the reserved bits zeroed.
    function automatic logic [CMD_W-1:0] make_cmd(
        input logic [3:0] op,
        input logic [5:0] slot,
        input logic [9:0] x,
        input logic [9:0] y,
        input logic [8:0] base
    );
        return {op, slot, x, y, base, 9'd0};
    endfunction

endpackage

// File: rtl/slot_bank_ram.sv
// Two banks of sprite slots: shadow-bank write port, registered renderer read
// port and a combinational copy read port, both reading the active bank.
module slot_bank_ram
    import render_cmd_pkg::*;
#(
    parameter int N_SLOTS = 32,
    parameter int SLOT_W  = 5
) (
    input  logic               clk50,
    input  logic               reset,
    input  logic               wr_bank,
    input  logic [SLOT_W-1:0]  wr_addr,
    input  logic               wr_data_en,
    input  logic               wr_valid_en,
    input  logic [ENTRY_W-1:0] wr_entry,
    input  logic               rd_bank,
    input  logic [SLOT_W-1:0]  rd_addr,
    output logic [ENTRY_W-1:0] rd_entry,
    input  logic [SLOT_W-1:0]  cp_addr,
    output logic [ENTRY_W-1:0] cp_entry
);

    localparam int DEPTH  = 2 * N_SLOTS;
    localparam int DATA_W = ENTRY_W - 1;

    // Coordinates live in plain RAM; only the valid bits need a reset.
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0]  valid_bits;
    logic [SLOT_W:0]   wr_index;
    logic [SLOT_W:0]   rd_index;
    logic [SLOT_W:0]   cp_index;

    assign wr_index = {wr_bank, wr_addr};
    assign rd_index = {rd_bank, rd_addr};
    assign cp_index = {rd_bank, cp_addr};

    always_ff @(posedge clk50) begin
        if (wr_data_en) begin
            data_mem[wr_index] <= wr_entry[DATA_W-1:0];
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
            logic valid_reg;
            always_ff @(posedge clk50 or posedge reset) begin
                if (reset) begin
                    valid_reg <= 1'b0;
                end else if (wr_valid_en && (wr_index == (SLOT_W+1)'(gi))) begin
                    valid_reg <= wr_entry[ENTRY_W-1];
                end
            end
            assign valid_bits[gi] = valid_reg;
        end
    endgenerate

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            rd_entry <= '0;
        end else begin
            rd_entry <= {valid_bits[rd_index], data_mem[rd_index]};
        end
    end

    assign cp_entry = {valid_bits[cp_index], data_mem[cp_index]};

endmodule

// File: rtl/render_cmd_reader.sv
// Render-queue consumer: pops commands, edits the shadow sprite bank and swaps
// banks on the first frame_start after a COMMIT, then resyncs the shadow bank.
module render_cmd_reader
    import render_cmd_pkg::*;
#(
    parameter int N_SLOTS = 32,
    parameter int SLOT_W  = 5
) (
    input  logic              clk50,
    input  logic              reset,
    input  logic              q_empty,
    input  logic [47:0]       q_dout,
    output logic              q_pop_front,
    input  logic              frame_start,
    input  logic [SLOT_W-1:0] rd_slot,
    output logic              rd_valid,
    output logic [9:0]        rd_x,
    output logic [9:0]        rd_y,
    output logic [8:0]        rd_base,
    output logic              active_bank,
    output logic [15:0]       cmd_count,
    output logic              err_opcode
);

    state_t                     state_reg, state_next;
    logic [CMD_W-1:BASE_LSB]    cmd_reg;
    logic [SLOT_W-1:0]          idx_reg;
    logic                       active_bank_reg;
    logic [15:0]                cmd_count_reg;
    logic                       err_reg;

    logic [OP_W-1:0]            op;
    logic [SLOT_FIELD_W-1:0]    slot_field;
    logic                       slot_ok;
    logic                       cmd_ok;
    logic                       idx_last;

    logic                       pop;
    logic                       count_inc;
    logic                       err_set;
    logic                       idx_clr;
    logic                       idx_inc;
    logic                       bank_flip;
    logic                       wr_data_en;
    logic                       wr_valid_en;
    logic [SLOT_W-1:0]          wr_addr;
    slot_entry_t                wr_entry_s;
    slot_entry_t                cp_entry_s;
    slot_entry_t                rd_entry_s;
    logic                       unused_reserved;

    assign unused_reserved = ^q_dout[BASE_LSB-1:0];

    assign op         = cmd_reg[OP_LSB +: OP_W];
    assign slot_field = cmd_reg[SLOT_LSB +: SLOT_FIELD_W];
    assign slot_ok    = (slot_field >> SLOT_W) == '0;
    assign cmd_ok     = (op <= OP_COMMIT) &&
                        (slot_ok || !((op == OP_SET) || (op == OP_CLEAR_SLOT)));
    assign idx_last   = idx_reg == SLOT_W'(N_SLOTS - 1);

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:       if (!q_empty) state_next = ST_EXEC;
            ST_EXEC: begin
                if (cmd_ok && (op == OP_CLEAR_ALL))   state_next = ST_CLEAR;
                else if (cmd_ok && (op == OP_COMMIT)) state_next = ST_WAIT_FRAME;
                else                                  state_next = ST_IDLE;
            end
            ST_CLEAR:      if (idx_last) state_next = ST_IDLE;
            ST_WAIT_FRAME: if (frame_start) state_next = ST_COPY;
            ST_COPY:       if (idx_last) state_next = ST_IDLE;
            default:       state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        pop         = 1'b0;
        count_inc   = 1'b0;
        err_set     = 1'b0;
        idx_clr     = 1'b0;
        idx_inc     = 1'b0;
        bank_flip   = 1'b0;
        wr_data_en  = 1'b0;
        wr_valid_en = 1'b0;
        wr_addr     = idx_reg;
        wr_entry_s  = '0;
        case (state_reg)
            ST_IDLE: pop = !q_empty;
            ST_EXEC: begin
                idx_clr = 1'b1;
                if (cmd_ok) begin
                    count_inc = 1'b1;
                    if (op == OP_SET) begin
                        wr_data_en  = 1'b1;
                        wr_valid_en = 1'b1;
                        wr_addr     = slot_field[SLOT_W-1:0];
                        wr_entry_s  = '{valid: 1'b1,
                                        x:     cmd_reg[X_LSB +: COORD_W],
                                        y:     cmd_reg[Y_LSB +: COORD_W],
                                        base:  cmd_reg[BASE_LSB +: BASE_W]};
                    end else if (op == OP_CLEAR_SLOT) begin
                        wr_valid_en = 1'b1;
                        wr_addr     = slot_field[SLOT_W-1:0];
                    end
                end else begin
                    err_set = 1'b1;
                end
            end
            ST_CLEAR: begin
                wr_valid_en = 1'b1;
                idx_inc     = 1'b1;
            end
            ST_WAIT_FRAME: begin
                bank_flip = frame_start;
                idx_clr   = frame_start;
            end
            ST_COPY: begin
                // Shadow is resynced from the freshly displayed bank.
                wr_data_en  = 1'b1;
                wr_valid_en = 1'b1;
                wr_entry_s  = cp_entry_s;
                idx_inc     = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            cmd_reg         <= '0;
            idx_reg         <= '0;
            active_bank_reg <= 1'b0;
            cmd_count_reg   <= '0;
            err_reg         <= 1'b0;
        end else begin
            if (pop) cmd_reg <= q_dout[CMD_W-1:BASE_LSB];
            if (count_inc) cmd_count_reg <= cmd_count_reg + 16'd1;
            if (err_set) err_reg <= 1'b1;
            if (bank_flip) active_bank_reg <= ~active_bank_reg;
            if (idx_clr) begin
                idx_reg <= '0;
            end else if (idx_inc) begin
                idx_reg <= idx_reg + SLOT_W'(1);
            end
        end
    end

    slot_bank_ram #(
        .N_SLOTS (N_SLOTS),
        .SLOT_W  (SLOT_W)
    ) u_banks (
        .clk50       (clk50),
        .reset       (reset),
        .wr_bank     (~active_bank_reg),
        .wr_addr     (wr_addr),
        .wr_data_en  (wr_data_en),
        .wr_valid_en (wr_valid_en),
        .wr_entry    (wr_entry_s),
        .rd_bank     (active_bank_reg),
        .rd_addr     (rd_slot),
        .rd_entry    (rd_entry_s),
        .cp_addr     (idx_reg),
        .cp_entry    (cp_entry_s)
    );

    assign q_pop_front = pop && !reset;
    assign rd_valid    = rd_entry_s.valid;
    assign rd_x        = rd_entry_s.x;
    assign rd_y        = rd_entry_s.y;
    assign rd_base     = rd_entry_s.base;
    assign active_bank = active_bank_reg;
    assign cmd_count   = cmd_count_reg;
    assign err_opcode  = err_reg;

endmodule

// File: tb/tb_render_cmd_reader.sv
// Randomized scoreboard bench for render_cmd_reader against a table-level model.
module tb_render_cmd_reader;
    import render_cmd_pkg::*;

    localparam int N_SLOTS = 32;
    localparam int SLOT_W  = 5;

    logic              clk50 = 1'b0;
    logic              reset = 1'b1;
    logic              q_empty = 1'b1;
    logic [47:0]       q_dout = '0;
    logic              q_pop_front;
    logic              frame_start = 1'b0;
    logic [SLOT_W-1:0] rd_slot = '0;
    logic              rd_valid;
    logic [9:0]        rd_x;
    logic [9:0]        rd_y;
    logic [8:0]        rd_base;
    logic              active_bank;
    logic [15:0]       cmd_count;
    logic              err_opcode;
    logic              rd_req = 1'b0;

    always #10 clk50 = ~clk50;

    render_cmd_reader #(.N_SLOTS(N_SLOTS), .SLOT_W(SLOT_W)) dut (
        .clk50       (clk50),
        .reset       (reset),
        .q_empty     (q_empty),
        .q_dout      (q_dout),
        .q_pop_front (q_pop_front),
        .frame_start (frame_start),
        .rd_slot     (rd_slot),
        .rd_valid    (rd_valid),
        .rd_x        (rd_x),
        .rd_y        (rd_y),
        .rd_base     (rd_base),
        .active_bank (active_bank),
        .cmd_count   (cmd_count),
        .err_opcode  (err_opcode)
    );

    typedef struct {
        bit       v;
        bit [9:0] x;
        bit [9:0] y;
        bit [8:0] b;
    } ent_t;

    typedef struct {
        int        slot;
        bit        v;
        bit [9:0]  x;
        bit [9:0]  y;
        bit [8:0]  b;
        bit        chk_data;
        bit        bank;
        bit [15:0] cnt;
        bit        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [47:0] fifo[$];
    int          pop_cycles[$];
    int          cycle = 0;
    int          n_vec = 0;
    int          n_miss = 0;

    // Reference model: what the HPS would believe the tables hold.
    ent_t        m_shadow[N_SLOTS];
    ent_t        m_display[N_SLOTS];
    logic [47:0] m_pend[$];
    bit          m_blocked = 0;
    bit          m_bank = 0;
    bit          m_err = 0;
    bit [15:0]   m_count = 0;

    logic              st_frame = 0;
    logic              st_req = 0;
    logic              st_reset = 1;
    logic [SLOT_W-1:0] st_slot = '0;

    function automatic void model_exec(input logic [47:0] c);
        int op = int'(c[47:44]);
        int s  = int'(c[43:38]);
        case (op)
            0: m_count++;
            1: if (s < N_SLOTS) begin
                   m_shadow[s] = '{1'b1, c[37:28], c[27:18], c[17:9]};
                   m_count++;
               end else m_err = 1;
            2: if (s < N_SLOTS) begin
                   m_shadow[s].v = 1'b0;
                   m_count++;
               end else m_err = 1;
            3: begin
                   foreach (m_shadow[i]) m_shadow[i].v = 1'b0;
                   m_count++;
               end
            4: begin
                   m_count++;
                   m_blocked = 1;
               end
            default: m_err = 1;
        endcase
    endfunction

    function automatic void model_run();
        while (!m_blocked && m_pend.size() > 0) model_exec(m_pend.pop_front());
    endfunction

    function automatic void model_frame();
        if (m_blocked) begin
            m_bank    = ~m_bank;
            m_display = m_shadow;
            m_blocked = 0;
            model_run();
        end
    endfunction

    function automatic void model_reset();
        foreach (m_shadow[i]) begin
            m_shadow[i]  = '{1'b0, 10'd0, 10'd0, 9'd0};
            m_display[i] = '{1'b0, 10'd0, 10'd0, 9'd0};
        end
        m_pend.delete();
        m_blocked = 0;
        m_bank    = 0;
        m_err     = 0;
        m_count   = 0;
    endfunction

    task automatic tick();
        bit pop_now;
        @(negedge clk50);
        reset       = st_reset;
        frame_start = st_frame;
        rd_req      = st_req;
        rd_slot     = st_slot;
        q_empty     = (fifo.size() == 0);
        q_dout      = q_empty ? 48'd0 : fifo[0];
        st_frame    = 0;
        st_req      = 0;
        #1 pop_now  = q_pop_front;
        @(posedge clk50);
        if (pop_now) begin
            void'(fifo.pop_front());
            pop_cycles.push_back(cycle);
        end
        cycle++;
    endtask

    task automatic send(input logic [47:0] c);
        fifo.push_back(c);
        m_pend.push_back(c);
        model_run();
    endtask

    task automatic settle();
        int budget = 0;
        int target = m_blocked ? m_pend.size() : 0;
        while (fifo.size() != target && budget < 5000) begin
            tick();
            budget++;
        end
        n_vec++;
        if (fifo.size() != target) begin
            n_miss++;
            $display("FAIL drain: queue depth %0d, required %0d", fifo.size(), target);
        end
        repeat (80) tick();
    endtask

    task automatic frame();
        st_frame = 1;
        tick();
        model_frame();
        settle();
    endtask

    task automatic do_read(input int s);
        exp_t e;
        e.slot     = s;
        e.v        = m_display[s].v;
        e.x        = m_display[s].x;
        e.y        = m_display[s].y;
        e.b        = m_display[s].b;
        e.chk_data = m_display[s].v || st_reset;
        e.bank     = m_bank;
        e.cnt      = m_count;
        e.err      = m_err;
        exp_q.push_back(e);
        st_req  = 1;
        st_slot = SLOT_W'(s);
        tick();
    endtask

    task automatic check_gap(input string name, input int idx, input int want);
        int got;
        n_vec++;
        got = (idx + 1 < pop_cycles.size()) ? pop_cycles[idx+1] - pop_cycles[idx] : -1;
        if (got != want) begin
            n_miss++;
            $display("FAIL %s: pop spacing %0d cycles, required %0d", name, got, want);
        end else begin
            $display("%s: pop spacing %0d cycles ok", name, got);
        end
    endtask

    function automatic logic [47:0] rand_cmd();
        int p = $urandom_range(0, 99);
        logic [3:0] op;
        logic [5:0] s;
        if (p < 45)      op = OP_SET;
        else if (p < 60) op = OP_CLEAR_SLOT;
        else if (p < 64) op = OP_CLEAR_ALL;
        else if (p < 80) op = OP_COMMIT;
        else if (p < 90) op = OP_NOP;
        else             op = 4'($urandom_range(5, 15));
        s = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(32, 63)) : 6'($urandom_range(0, 31));
        return make_cmd(op, s, 10'($urandom), 10'($urandom), 9'($urandom)) | 48'($urandom_range(0, 511));
    endfunction

    // Monitor: pop pulse width and registered read responses.
    bit prev_pop = 0;
    always @(posedge clk50) begin
        bit   req;
        bit   pop;
        exp_t e;
        req = rd_req;
        pop = q_pop_front;
        if (pop) begin
            n_vec++;
            if (prev_pop) begin
                n_miss++;
                $display("FAIL pop_width: q_pop_front high 2 cycles in a row, required 1");
            end
        end
        prev_pop = pop;
        if (req) begin
            #1;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL scoreboard: read response with no expectation queued");
            end else begin
                e = exp_q.pop_front();
                if (rd_valid !== e.v || active_bank !== e.bank || cmd_count !== e.cnt ||
                    err_opcode !== e.err ||
                    (e.chk_data && (rd_x !== e.x || rd_y !== e.y || rd_base !== e.b))) begin
                    n_miss++;
                    $display("FAIL read slot %0d: got v=%0b x=%0d y=%0d base=%0d bank=%0b cnt=%0d err=%0b, required v=%0b x=%0d y=%0d base=%0d bank=%0b cnt=%0d err=%0b",
                             e.slot, rd_valid, rd_x, rd_y, rd_base, active_bank, cmd_count, err_opcode,
                             e.v, e.x, e.y, e.b, e.bank, e.cnt, e.err);
                end else begin
                    $display("read slot %0d ok: v=%0b x=%0d y=%0d base=%0d bank=%0b cnt=%0d err=%0b",
                             e.slot, rd_valid, rd_x, rd_y, rd_base, active_bank, cmd_count, err_opcode);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_idx;
        model_reset();

        // Reset values.
        repeat (3) tick();
        do_read(0);
        st_reset = 0;
        repeat (2) tick();

        // SET without COMMIT is not displayed.
        send(make_cmd(OP_SET, 6'd3, 10'd100, 10'd50, 9'd7));
        settle();
        frame();
        do_read(3);

        // COMMIT then frame makes it visible.
        send(make_cmd(OP_COMMIT, 6'd0, 10'd0, 10'd0, 9'd0));
        settle();
        frame();
        do_read(3);

        // Fill the whole table, then CLEAR_ALL.
        base_idx = pop_cycles.size();
        for (int s = 0; s < N_SLOTS; s++)
            send(make_cmd(OP_SET, 6'(s), 10'($urandom), 10'($urandom), 9'($urandom)));
        send(make_cmd(OP_COMMIT, 6'd0, 10'd0, 10'd0, 9'd0));
        settle();
        check_gap("set_spacing", base_idx, 2);
        frame();
        for (int s = 0; s < N_SLOTS; s++) do_read(s);
        base_idx = pop_cycles.size();
        send(make_cmd(OP_CLEAR_ALL, 6'd0, 10'd0, 10'd0, 9'd0));
        send(make_cmd(OP_COMMIT, 6'd0, 10'd0, 10'd0, 9'd0));
        settle();
        check_gap("clear_all_span", base_idx, 34);
        frame();
        for (int s = 0; s < N_SLOTS; s++) do_read(s);

        // Undefined opcode and out-of-range slot, then a good SET.
        send(make_cmd(4'd9, 6'd1, 10'd1, 10'd2, 9'd3));
        send(make_cmd(OP_SET, 6'd40, 10'd11, 10'd22, 9'd33));
        settle();
        do_read(0);
        send(make_cmd(OP_SET, 6'd5, 10'd321, 10'd123, 9'd200));
        send(make_cmd(OP_COMMIT, 6'd0, 10'd0, 10'd0, 9'd0));
        settle();
        frame();
        do_read(5);

        // frame_start coincident with the COMMIT's EXEC cycle is missed.
        send(make_cmd(OP_SET, 6'd5, 10'd9, 10'd8, 9'd7));
        settle();
        base_idx = pop_cycles.size();
        send(make_cmd(OP_COMMIT, 6'd0, 10'd0, 10'd0, 9'd0));
        for (int k = 0; k < 50 && pop_cycles.size() == base_idx; k++) tick();
        st_frame = 1;
        tick();
        settle();
        do_read(5);
        frame();
        do_read(5);

        // Two COMMITs back to back need two frames.
        send(make_cmd(OP_SET, 6'd9, 10'd500, 10'd400, 9'd300));
        send(make_cmd(OP_COMMIT, 6'd0, 10'd0, 10'd0, 9'd0));
        send(make_cmd(OP_SET, 6'd9, 10'd501, 10'd401, 9'd301));
        send(make_cmd(OP_COMMIT, 6'd0, 10'd0, 10'd0, 9'd0));
        settle();
        frame();
        do_read(9);
        frame();
        do_read(9);

        // Randomized rounds.
        for (int r = 0; r < 25; r++) begin
            int n = $urandom_range(3, 8);
            for (int k = 0; k < n; k++) send(rand_cmd());
            settle();
            for (int g = 0; g < 4 && m_blocked; g++) frame();
            for (int k = 0; k < 6; k++) do_read($urandom_range(0, N_SLOTS - 1));
        end
        while (m_blocked) frame();

        // Reset in the middle of COPY.
        send(make_cmd(OP_SET, 6'd7, 10'd77, 10'd66, 9'd55));
        send(make_cmd(OP_COMMIT, 6'd0, 10'd0, 10'd0, 9'd0));
        settle();
        st_frame = 1;
        tick();
        model_frame();
        repeat (5) tick();
        fifo.push_back(make_cmd(OP_NOP, 6'd0, 10'd0, 10'd0, 9'd0));
        st_reset = 1;
        model_reset();
        do_read(7);
        #1;
        n_vec++;
        if (q_pop_front !== 1'b0) begin
            n_miss++;
            $display("FAIL pop_in_reset: q_pop_front=%0b, required 0", q_pop_front);
        end
        fifo.delete();
        tick();
        st_reset = 0;
        repeat (2) tick();
        send(make_cmd(OP_SET, 6'd7, 10'd12, 10'd34, 9'd56));
        send(make_cmd(OP_COMMIT, 6'd0, 10'd0, 10'd0, 9'd0));
        settle();
        frame();
        do_read(7);

        repeat (5) tick();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard_leftover: %0d responses outstanding, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/render_cmd_reader.md
# render_cmd_reader

Consumer end of the 48-bit render queue that the HPS fills byte-by-byte. Pops render commands from the render-queue FIFO, decodes them, and maintains a double-buffered sprite slot table. The VGA display reads that table through a registered read port. Edits go to a shadow bank, and a COMMIT command makes them visible atomically at the next frame start.

## Interface
Parameters:
- N_SLOTS, 32: number of sprite slots per bank (power of two, at most 64)
- SLOT_W, 5: log2(N_SLOTS)

Ports:
- clk50  in  1  system clock; all logic on posedge
- reset  in  1  asynchronous, active-high; clears all state
- q_empty  in  1  render-queue FIFO empty
- q_dout  in  48  FIFO head word, first-word fall-through, valid while !q_empty
- q_pop_front  out  1  one-cycle pulse that consumes the head word
- frame_start  in  1  one-cycle pulse at start of vertical blank
- rd_slot  in  SLOT_W  renderer slot index (active bank)
- rd_valid  out  1  slot enabled (registered)
- rd_x  out  10  sprite x (registered)
- rd_y  out  10  sprite y (registered)
- rd_base  out  9  sprite base pixel index into image memory (registered)
- active_bank  out  1  bank currently visible to renderer
- cmd_count  out  16  commands executed, wraps at 65535 -> 0
- err_opcode  out  1  sticky; set on undefined opcode, cleared only by reset

## Operation
- Command word fields:
  - [47:44] opcode
  - [43:38] slot; bits above SLOT_W must be 0, otherwise the command is an error
  - [37:28] x
  - [27:18] y
  - [17:9] base
  - [8:0] reserved and ignored
- Opcodes:
  - 0 NOP: counted, no other effect
  - 1 SET: shadow[slot] <= {valid=1, x, y, base}
  - 2 CLEAR_SLOT: shadow[slot].valid <= 0
  - 3 CLEAR_ALL: all shadow valid bits <= 0, one slot per cycle
  - 4 COMMIT: bank swap at the next frame_start
  - 5..15: set err_opcode and discard; cmd_count does not increment
- Out-of-range slot on SET or CLEAR_SLOT: set err_opcode and discard.
- FSM states: IDLE, EXEC, CLEAR, WAIT_FRAME, COPY.
  - IDLE: if !q_empty, pulse q_pop_front, latch q_dout into cmd_reg, go to EXEC.
  - EXEC: SET, CLEAR_SLOT, NOP and error cases return to IDLE. CLEAR_ALL goes to CLEAR with idx=0. COMMIT goes to WAIT_FRAME.
  - CLEAR: clear shadow[idx], idx++. After idx = N_SLOTS-1, return to IDLE.
  - WAIT_FRAME: on frame_start, flip active_bank, set idx=0, go to COPY.
  - COPY: shadow[idx] <= new active[idx], idx++. After N_SLOTS-1, return to IDLE. This makes the shadow bank start equal to the displayed bank, so later edits are incremental.
- No pops occur in EXEC, CLEAR, WAIT_FRAME or COPY.
- cmd_count increments in EXEC for valid commands only.

## Timing
- Reset values:
  - q_pop_front=0, active_bank=0, cmd_count=0, err_opcode=0
  - rd_valid=0, rd_x=0, rd_y=0, rd_base=0
  - all valid bits in both banks = 0; state IDLE
- Pop handshake: q_pop_front is high for exactly one cycle, the same cycle q_dout is latched. Minimum spacing between pops is 2 cycles (IDLE then EXEC). The earliest next pop is the cycle after EXEC.
- Latency:
  - SET to shadow takes 2 cycles from the pop.
  - SET is visible on rd_* only after COMMIT plus frame_start plus 1 cycle of read latency.
- Read port: rd_* reflect active[rd_slot] one cycle after rd_slot is presented. This holds during every state.
- frame_start outside WAIT_FRAME is ignored.
- frame_start in the same cycle as the EXEC of a COMMIT is missed; the swap waits for the following frame_start.
- At most one swap per frame_start. A second COMMIT queued behind the first waits for a later frame.
- Reset asserted mid-CLEAR, mid-WAIT_FRAME or mid-COPY aborts immediately to the reset values. A word latched but not yet executed is lost.

## Structure
- Shared package render_cmd_pkg holds:
  - opcode localparams (OP_NOP..OP_COMMIT)
  - field bit-position constants
  - a packed struct slot_entry_t {valid, x[9:0], y[9:0], base[8:0]}
  - the FSM state enum
- The package is also imported by the HPS-side command assembly and by the testbench.
- One sub-module, slot_bank_ram: a dual bank of N_SLOTS x slot_entry_t.
  - One write port targets the shadow bank.
  - One registered read port serves the renderer (active bank).
  - One combinational read port serves COPY (active bank).

## Test plan
- Reset, then SET slot 3 (x=100, y=50, base=7), then COMMIT, then a frame_start pulse, then read slot 3 -> rd_valid=1, rd_x=100, rd_y=50, rd_base=7; active_bank=1; cmd_count=2.
- SET slot 3 without COMMIT, with frame_start pulsed -> rd_valid for slot 3 stays 0; active_bank stays 0.
- SET slots 0..31, COMMIT, frame, then CLEAR_ALL, COMMIT, frame -> all slots read rd_valid=0. The CLEAR span shows no q_pop_front for 32 cycles.
- Opcode 9, then slot index 40 on SET -> err_opcode=1 with cmd_count unchanged; the next valid SET still executes.
- COMMIT with frame_start coincident with its EXEC cycle -> no swap; swap occurs on the next frame_start pulse.
- Reset asserted during COPY -> all outputs return to their reset values on the next edge; subsequent commands execute normally.
